// File: rtl/dec_scan_pkg.sv
// dec_scan_pkg: mode and state encodings shared by the decoder/scan blocks
package dec_scan_pkg;
  localparam logic [1:0] MODE_DIRECT      = 2'b00;
  localparam logic [1:0] MODE_THERMO      = 2'b01;
  localparam logic [1:0] MODE_SCAN_WRAP   = 2'b10;
  localparam logic [1:0] MODE_SCAN_BOUNCE = 2'b11;
  localparam logic [1:0] ST_IDLE      = 2'b00;
  localparam logic [1:0] ST_DIRECT    = 2'b01;
  localparam logic [1:0] ST_SCAN_UP   = 2'b10;
  localparam logic [1:0] ST_SCAN_DOWN = 2'b11;
endpackage

// File: rtl/decoder_scan_n_tick_gen.sv
// tick_gen: prescaler counting 0..DIV_MAX while run, strobing tick at terminal count
module tick_gen #(
  parameter int DIV_W = 24,
  parameter logic [DIV_W-1:0] DIV_MAX = DIV_W'(12_000_000 - 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);
  logic [DIV_W-1:0] cnt;
  assign tick = run & (cnt == DIV_MAX);
  always_ff @(posedge clk)
    if (rst || clear) cnt <= '0;
    else if (run) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/decoder_scan_n.sv
// decoder_scan_n: registered N-to-2^N decoder with thermometer mode and wrap/bounce scan sequencer
module decoder_scan_n
  import dec_scan_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int OUT_W = 2 ** SEL_W,
  parameter int DIV_W = 24,
  parameter logic [DIV_W-1:0] DIV_MAX = DIV_W'(12_000_000 - 1),
  parameter bit ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] y,
  output logic [SEL_W-1:0] idx,
  output logic             tick
);
  localparam logic [SEL_W-1:0] TOP = SEL_W'(OUT_W - 1);
  localparam logic [OUT_W-1:0] INV = {OUT_W{ACTIVE_LOW}};
  logic [1:0] state, state_n;
  logic dir, dir_n, held, held_n, scan_now, pulse, bounce, edir, sdir;
  logic [SEL_W-1:0] idx_n, sidx;
  logic [OUT_W-1:0] oh, th, y_n;
  tick_gen #(.DIV_W(DIV_W), .DIV_MAX(DIV_MAX)) u_tick (
    .clk(clk),
    .rst(rst),
    .run(scan_now),
    .clear(en & ~scan_now),
    .tick(pulse)
  );
  // held remembers a frozen scan so re-enabling resumes instead of reloading from sel
  always_comb begin
    scan_now = en & mode[1] & (state[1] | (state == ST_IDLE & held));
    bounce = mode == MODE_SCAN_BOUNCE;
    edir = bounce & (idx == TOP | (idx != '0 & dir));
    sidx = edir ? idx - 1'b1 : idx + 1'b1;
    sdir = bounce & (sidx == TOP | (sidx != '0 & edir));
    idx_n = !en ? idx : !scan_now ? sel : pulse ? sidx : idx;
    dir_n = !en ? dir : !scan_now ? 1'b0 : pulse ? sdir : bounce & dir;
    held_n = en ? mode[1] : held;
    state_n = !en ? ST_IDLE : !mode[1] ? ST_DIRECT : dir_n ? ST_SCAN_DOWN : ST_SCAN_UP;
    oh = '0;
    th = '0;
    for (int i = 0; i < OUT_W; i++) begin
      oh[i] = idx_n == SEL_W'(i);
      th[i] = SEL_W'(i) <= idx_n;
    end
    y_n = state_n == ST_IDLE ? '0 : (state_n == ST_DIRECT && mode == MODE_THERMO) ? th : oh;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      dir <= 1'b0;
      held <= 1'b0;
      idx <= '0;
      tick <= 1'b0;
      y <= INV;
    end else begin
      state <= state_n;
      dir <= dir_n;
      held <= held_n;
      idx <= idx_n;
      tick <= pulse;
      y <= y_n ^ INV;
    end
endmodule

// File: tb/tb_decoder_scan_n.sv
// tb_decoder_scan_n: vector table for a slow-prescaler instance plus hand sequences for fast/active-low/1-bit instances
module tb_decoder_scan_n;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic r0, e0, r1, e1, r2, e2, s2, i2, t0, t1, t2;
  logic [1:0] m0, m1, m2, s0, s1, i0, i1, y2;
  logic [3:0] y0, y1, exp4;
  int checks = 0, errors = 0;
  int seq1[10] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2};
  int seq2[4] = '{1, 0, 1, 0};
  decoder_scan_n #(.SEL_W(2), .DIV_MAX(24'd3), .ACTIVE_LOW(0)) d0 (
    .clk(clk), .rst(r0), .en(e0), .mode(m0), .sel(s0), .y(y0), .idx(i0), .tick(t0));
  decoder_scan_n #(.SEL_W(2), .DIV_MAX(24'd0), .ACTIVE_LOW(1)) d1 (
    .clk(clk), .rst(r1), .en(e1), .mode(m1), .sel(s1), .y(y1), .idx(i1), .tick(t1));
  decoder_scan_n #(.SEL_W(1), .DIV_MAX(24'd0), .ACTIVE_LOW(0)) d2 (
    .clk(clk), .rst(r2), .en(e2), .mode(m2), .sel(s2), .y(y2), .idx(i2), .tick(t2));
  typedef struct {
    logic rst, en;
    logic [1:0] mode, sel;
    logic [3:0] y;
    logic [1:0] idx;
    logic tick;
  } vec_t;
  vec_t tv[$];
  task automatic add(input logic rst, en, input logic [1:0] mode, sel, input logic [3:0] y,
                     input logic [1:0] idx, input logic tick, input int n = 1);
    vec_t v;
    v = '{rst, en, mode, sel, y, idx, tick};
    for (int k = 0; k < n; k++) tv.push_back(v);
  endtask
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    {r1, e1, m1, s1, r2, e2, m2, s2} = '1;
    {e1, e2} = 2'b00;
    add(1, 0, 0, 0, 4'b0000, 0, 0, 2);
    add(0, 1, 0, 2, 4'b0100, 2, 0);
    add(0, 1, 0, 3, 4'b1000, 3, 0);
    add(0, 1, 1, 1, 4'b0011, 1, 0);
    add(0, 1, 1, 3, 4'b1111, 3, 0);
    add(0, 0, 1, 3, 4'b0000, 3, 0);
    add(0, 1, 2, 2, 4'b0100, 2, 0);
    add(0, 1, 2, 0, 4'b0100, 2, 0, 3);
    add(0, 1, 2, 0, 4'b1000, 3, 1);
    add(0, 1, 2, 0, 4'b1000, 3, 0, 3);
    add(0, 1, 2, 0, 4'b0001, 0, 1);
    add(0, 1, 2, 0, 4'b0001, 0, 0, 3);
    add(0, 1, 2, 0, 4'b0010, 1, 1);
    add(0, 1, 2, 0, 4'b0010, 1, 0, 2);
    add(0, 0, 2, 0, 4'b0000, 1, 0, 10);
    add(0, 1, 2, 0, 4'b0010, 1, 0);
    add(0, 1, 2, 0, 4'b0100, 2, 1);
    add(0, 1, 3, 0, 4'b0100, 2, 0, 3);
    add(0, 1, 3, 0, 4'b1000, 3, 1);
    add(0, 1, 3, 0, 4'b1000, 3, 0, 3);
    add(0, 1, 3, 0, 4'b0100, 2, 1);
    add(0, 1, 2, 0, 4'b0100, 2, 0, 3);
    add(0, 1, 2, 0, 4'b1000, 3, 1);
    add(1, 1, 2, 0, 4'b0000, 0, 0);
    add(0, 1, 2, 1, 4'b0010, 1, 0, 4);
    add(0, 1, 2, 1, 4'b0100, 2, 1);
    for (int k = 0; k < tv.size(); k++) begin
      r0 = tv[k].rst; e0 = tv[k].en; m0 = tv[k].mode; s0 = tv[k].sel;
      cyc();
      cmp($sformatf("d0[%0d].y", k), y0, tv[k].y);
      cmp($sformatf("d0[%0d].idx", k), i0, tv[k].idx);
      cmp($sformatf("d0[%0d].tick", k), t0, tv[k].tick);
    end
    r1 = 1; e1 = 0; m1 = 0; s1 = 0;
    cyc(); cyc();
    cmp("d1 rst y", y1, 4'hF); cmp("d1 rst idx", i1, 0); cmp("d1 rst tick", t1, 0);
    r1 = 0; e1 = 1; m1 = 1; s1 = 1; cyc();
    cmp("d1 thermo1 y", y1, 4'b1100);
    s1 = 0; cyc();
    cmp("d1 thermo0 y", y1, 4'b1110);
    e1 = 0; cyc();
    cmp("d1 disable y", y1, 4'b1111);
    e1 = 1; m1 = 3; s1 = 0; cyc();
    cmp("d1 load y", y1, 4'b1110); cmp("d1 load idx", i1, 0); cmp("d1 load tick", t1, 0);
    for (int k = 0; k < 10; k++) begin
      cyc();
      exp4 = ~(4'b0001 << seq1[k]);
      cmp($sformatf("d1 bounce[%0d].idx", k), i1, seq1[k]);
      cmp($sformatf("d1 bounce[%0d].y", k), y1, exp4);
      cmp($sformatf("d1 bounce[%0d].tick", k), t1, 1);
    end
    r1 = 1; cyc();
    cmp("d1 midrst y", y1, 4'hF); cmp("d1 midrst idx", i1, 0); cmp("d1 midrst tick", t1, 0);
    r1 = 0; s1 = 2; cyc();
    cmp("d1 reload idx", i1, 2); cmp("d1 reload y", y1, 4'b1011); cmp("d1 reload tick", t1, 0);
    cyc();
    cmp("d1 after reload idx", i1, 3); cmp("d1 after reload tick", t1, 1);
    r2 = 1; e2 = 0; cyc();
    cmp("d2 rst idx", i2, 0); cmp("d2 rst y", y2, 0);
    r2 = 0; e2 = 1; m2 = 3; s2 = 0; cyc();
    cmp("d2 load idx", i2, 0); cmp("d2 load y", y2, 2'b01); cmp("d2 load tick", t2, 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      cmp($sformatf("d2 bounce[%0d].idx", k), i2, seq2[k]);
      cmp($sformatf("d2 bounce[%0d].y", k), y2, seq2[k] == 1 ? 2'b10 : 2'b01);
      cmp($sformatf("d2 bounce[%0d].tick", k), t2, 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decoder_scan_n.md
Name: decoder_scan_n

Overview:
Parametrised, registered N-to-2^N decoder with enable. It is the next-generation LED/digit-select driver for the STEPFPGA boards. It adds a thermometer mode and an autonomous scan sequencer (wrap or bounce) paced by an internal prescaler. Typical uses are walking-LED patterns and 7-segment digit strobing, driven from switches or a control FSM.

Parameters:
SEL_W, 2, width of sel/idx; must be >= 1.
OUT_W, 2**SEL_W, output width; fixed at 2**SEL_W and must not be overridden.
DIV_W, 24, prescaler counter width.
DIV_MAX, 12_000_000-1, terminal count for the prescaler; one scan step every DIV_MAX+1 clocks (1 s at 12 MHz).
ACTIVE_LOW, 0, 1 = invert y at the output register (common-anode / active-low LEDs).

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  enable; 0 forces y inactive and freezes the sequencer
mode  in  2  00 DIRECT one-hot, 01 THERMO, 10 SCAN_WRAP, 11 SCAN_BOUNCE
sel  in  SEL_W  index in DIRECT/THERMO; start index when scan is entered
y  out  OUT_W  registered decoded output (polarity per ACTIVE_LOW)
idx  out  SEL_W  registered index currently driven on y
tick  out  1  one-cycle pulse on the cycle idx advances in a scan mode

Behaviour:
- Reset (rst=1 at a clock edge; overrides everything):
  - y = all-inactive (0s, or 1s if ACTIVE_LOW).
  - idx = 0, tick = 0, prescaler = 0, direction = up, state = IDLE.
- State machine: IDLE, DIRECT, SCAN_UP, SCAN_DOWN. THERMO shares DIRECT with a different output encoding.
  - en=0 from any state -> IDLE next cycle. In IDLE:
    - y inactive, tick = 0.
    - idx, prescaler and direction are held, not cleared.
  - en=1, mode 00/01 -> DIRECT.
    - idx <= sel each cycle, prescaler <= 0.
  - en=1, mode 1x, entered from IDLE or DIRECT:
    - go to SCAN_UP; load idx <= sel, prescaler <= 0, direction = up.
    - The first step occurs DIV_MAX+1 cycles later.
  - In SCAN_UP / SCAN_DOWN, the prescaler counts 0..DIV_MAX.
    - At DIV_MAX it returns to 0, tick = 1 for that cycle, and idx steps.
- Step rules:
  - SCAN_WRAP: idx + 1 modulo OUT_W (OUT_W-1 -> 0); the state stays SCAN_UP.
  - SCAN_BOUNCE, from SCAN_UP: step up; on reaching OUT_W-1 -> SCAN_DOWN.
  - SCAN_BOUNCE, from SCAN_DOWN: step down; on reaching 0 -> SCAN_UP.
  - Each endpoint appears for exactly one step period (0,1,2,3,2,1,0,1,...).
  - SEL_W=1 bounce alternates 0,1.
- Switching between the two scan modes mid-scan keeps idx and the prescaler.
  - Bounce -> wrap forces direction up.
  - Wrap -> bounce continues upward.
- Output encoding:
  - Computed from the next-state idx and registered with it, so y and idx always agree.
  - DIRECT/scan: y[i] = (i == idx).
  - THERMO: y[i] = (i <= idx), so sel=0 lights bit 0 only and sel=OUT_W-1 lights all bits.
- Latency:
  - sel -> y/idx is 1 clock in DIRECT/THERMO.
  - en falling -> y inactive is 1 clock.
  - tick is registered and coincident with the new idx/y.
- DIV_MAX = 0: a step every cycle while scanning, tick constantly 1.
- sel changes during scan are ignored.
- Reset mid-scan aborts immediately; the next start reloads from sel.

Decomposition:
- Package dec_scan_pkg:
  - mode constants MODE_DIRECT, MODE_THERMO, MODE_SCAN_WRAP, MODE_SCAN_BOUNCE.
  - state encoding for IDLE, DIRECT, SCAN_UP, SCAN_DOWN.
- One sub-module: tick_gen (DIV_W, DIV_MAX; inputs clk, rst, run, clear; output tick).
  - Reusable by other timing blocks in the tutorial set.
- Decode and sequencer logic stay in decoder_scan_n.

Test Plan:
- Reset and direct, SEL_W=2: rst held 2 cycles -> y=0000, idx=0, tick=0. Then en=1, mode=00, sel=2 -> y=0100 one clock later; sel=3 -> y=1000.
- Thermometer, ACTIVE_LOW=1: mode=01, sel=1 -> y=1100 (bits 1:0 active low); sel=0 -> y=1110. en=0 -> y=1111 next clock.
- Wrap scan, DIV_MAX=3: en=1, mode=10, sel=2 -> idx sequence 2,3,0,1,2 changing every 4 cycles. tick pulses exactly on each change.
- Bounce scan, DIV_MAX=0, SEL_W=2: start sel=0 -> idx 0,1,2,3,2,1,0,1 on consecutive cycles. Also SEL_W=1 -> 0,1,0,1.
- Freeze and resume: en=0 mid-scan at idx=1, prescaler=2 for 10 cycles -> y inactive, idx=1 held. en=1 with mode unchanged -> the next tick comes after the remaining prescaler counts, with no reload from sel.
- Reset mid-scan and mode hop: rst during SCAN_DOWN -> all outputs at reset values next clock. Separately, switching bounce->wrap while in SCAN_DOWN at idx=2 -> next step gives idx=3.
